// File: rtl/pll_reconfig_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pll_reconfig_sequencer
//  Purpose  : Sequences the rPLL that derives the core/video clock from the
//             27 MHz reference. Holds the PLL in reset, qualifies lock, then
//             releases the downstream system reset. Recovers from lock loss
//             with bounded retries and switches between four divider profiles
//             through the rPLL dynamic IDSEL/FBDSEL/ODSEL inputs. Runs on the
//             reference clock only.
//  Ports    : clk, rst_n         - reference clock, async active-low reset
//             pll_lock_i         - rPLL LOCK (asynchronous, synchronized here)
//             prof_sel_i/req_i   - profile index and request strobe
//             prof_ack_o         - one-cycle pulse when a requested profile runs
//             pll_reset_o        - rPLL RESET
//             pll_*sel_o         - rPLL divider selects
//             sys_rst_n_o        - downstream reset, active low, registered
//             locked_o/busy_o/fault_o/retry_cnt_o - status
//  Revision : 1.0 - initial release
// ============================================================================
module pll_reconfig_sequencer #(
  parameter int          RST_CYCLES    = 27,
  parameter int          LOCK_TIMEOUT  = 27000,
  parameter int          STABLE_CYCLES = 270,
  parameter int          MAX_RETRY     = 3,
  parameter logic [23:0] IDSEL_TABLE   = 24'h0,
  parameter logic [23:0] FBDSEL_TABLE  = 24'h0,
  parameter logic [23:0] ODSEL_TABLE   = 24'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock_i,
  input  logic [1:0] prof_sel_i,
  input  logic       prof_req_i,
  output logic       prof_ack_o,
  output logic       pll_reset_o,
  output logic [5:0] pll_idsel_o,
  output logic [5:0] pll_fbdsel_o,
  output logic [5:0] pll_odsel_o,
  output logic       sys_rst_n_o,
  output logic       locked_o,
  output logic       busy_o,
  output logic       fault_o,
  output logic [1:0] retry_cnt_o
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TMR_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  // One extra code so the counter can represent STABLE_CYCLES itself.
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  function automatic logic [5:0] pick(input logic [23:0] tbl, input logic [1:0] idx);
    logic [5:0] code;
    case (idx)
      2'd0:    code = tbl[5:0];
      2'd1:    code = tbl[11:6];
      2'd2:    code = tbl[17:12];
      default: code = tbl[23:18];
    endcase
    return code;
  endfunction

  state_e             state_q;
  logic [1:0]         lock_sync_q;
  logic [RST_W-1:0]   rst_cnt_q;
  logic [TMR_W-1:0]   timer_q;
  logic [STB_W-1:0]   stable_cnt_q;
  logic [1:0]         retry_q;
  logic [1:0]         prof_q;
  logic [1:0]         prof_d;
  logic               ack_pend_q;
  logic               prof_ack_q;
  logic               pll_reset_q;
  logic               sys_rst_n_q;
  logic               locked_q;
  logic               busy_q;
  logic               fault_q;
  logic [5:0]         idsel_q;
  logic [5:0]         fbdsel_q;
  logic [5:0]         odsel_q;
  logic               lock_s;
  logic               req_taken;

  // Lock comes from the PLL's own domain; two flops before any decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_lock_i};
    end
  end

  assign lock_s = lock_sync_q[1];

  // A request is honoured only in RUN or FAULT, and both lead straight to
  // HOLD, so the active profile can change only on a HOLD-entry edge.
  assign req_taken = prof_req_i && ((state_q == ST_RUN) || (state_q == ST_FAULT));

  always_comb begin
    prof_d = prof_q;
    if (req_taken) begin
      prof_d = prof_sel_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HOLD;
      rst_cnt_q    <= '0;
      timer_q      <= '0;
      stable_cnt_q <= '0;
      retry_q      <= 2'd0;
      prof_q       <= 2'd0;
      ack_pend_q   <= 1'b0;
      prof_ack_q   <= 1'b0;
      pll_reset_q  <= 1'b1;
      sys_rst_n_q  <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b1;
      fault_q      <= 1'b0;
      idsel_q      <= pick(IDSEL_TABLE, 2'd0);
      fbdsel_q     <= pick(FBDSEL_TABLE, 2'd0);
      odsel_q      <= pick(ODSEL_TABLE, 2'd0);
    end else begin
      prof_ack_q <= 1'b0;
      prof_q     <= prof_d;
      idsel_q    <= pick(IDSEL_TABLE, prof_d);
      fbdsel_q   <= pick(FBDSEL_TABLE, prof_d);
      odsel_q    <= pick(ODSEL_TABLE, prof_d);

      case (state_q)
        ST_HOLD: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q     <= ST_WAIT_LOCK;
            pll_reset_q <= 1'b0;
            rst_cnt_q   <= '0;
            timer_q     <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_q      <= ST_STABLE;
            stable_cnt_q <= STB_W'(1);
          end else if (timer_q == TMR_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_q     <= retry_q + 2'd1;
              state_q     <= ST_HOLD;
              pll_reset_q <= 1'b1;
              rst_cnt_q   <= '0;
            end else begin
              state_q     <= ST_FAULT;
              pll_reset_q <= 1'b1;
              busy_q      <= 1'b0;
              fault_q     <= 1'b1;
            end
          end else begin
            // Saturates at TMR_LAST; never wraps.
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_STABLE: begin
          if (!lock_s) begin
            // Dropout restarts qualification without consuming a retry.
            state_q      <= ST_WAIT_LOCK;
            stable_cnt_q <= '0;
            timer_q      <= '0;
          end else if (stable_cnt_q >= STB_LAST) begin
            state_q      <= ST_RUN;
            stable_cnt_q <= '0;
            sys_rst_n_q  <= 1'b1;
            locked_q     <= 1'b1;
            busy_q       <= 1'b0;
            retry_q      <= 2'd0;
            prof_ack_q   <= ack_pend_q;
            ack_pend_q   <= 1'b0;
          end else begin
            stable_cnt_q <= stable_cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          // Request outranks simultaneous lock loss; both resequence.
          if (prof_req_i || !lock_s) begin
            state_q     <= ST_HOLD;
            pll_reset_q <= 1'b1;
            rst_cnt_q   <= '0;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b1;
            if (prof_req_i) begin
              ack_pend_q <= 1'b1;
            end
          end
        end

        ST_FAULT: begin
          if (prof_req_i) begin
            state_q    <= ST_HOLD;
            rst_cnt_q  <= '0;
            retry_q    <= 2'd0;
            ack_pend_q <= 1'b1;
            fault_q    <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        default: begin
          state_q     <= ST_HOLD;
          rst_cnt_q   <= '0;
          pll_reset_q <= 1'b1;
          sys_rst_n_q <= 1'b0;
          locked_q    <= 1'b0;
          busy_q      <= 1'b1;
          fault_q     <= 1'b0;
        end
      endcase
    end
  end

  assign prof_ack_o   = prof_ack_q;
  assign pll_reset_o  = pll_reset_q;
  assign pll_idsel_o  = idsel_q;
  assign pll_fbdsel_o = fbdsel_q;
  assign pll_odsel_o  = odsel_q;
  assign sys_rst_n_o  = sys_rst_n_q;
  assign locked_o     = locked_q;
  assign busy_o       = busy_q;
  assign fault_o      = fault_q;
  assign retry_cnt_o  = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_reconfig_sequencer
//  Purpose  : Directed self-checking bench for pll_reconfig_sequencer with
//             RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
  // Profiles packed {p3, p2, p1, p0}
  localparam logic [23:0] IDSEL_TABLE  = {6'h07, 6'h1C, 6'h25, 6'h3A};
  localparam logic [23:0] FBDSEL_TABLE = {6'h33, 6'h2E, 6'h0F, 6'h11};
  localparam logic [23:0] ODSEL_TABLE  = {6'h3F, 6'h02, 6'h04, 6'h08};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock_i;
  logic [1:0] prof_sel_i;
  logic       prof_req_i;
  logic       prof_ack_o;
  logic       pll_reset_o;
  logic [5:0] pll_idsel_o;
  logic [5:0] pll_fbdsel_o;
  logic [5:0] pll_odsel_o;
  logic       sys_rst_n_o;
  logic       locked_o;
  logic       busy_o;
  logic       fault_o;
  logic [1:0] retry_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pll_reconfig_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .IDSEL_TABLE  (IDSEL_TABLE),
    .FBDSEL_TABLE (FBDSEL_TABLE),
    .ODSEL_TABLE  (ODSEL_TABLE)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock_i  (pll_lock_i),
    .prof_sel_i  (prof_sel_i),
    .prof_req_i  (prof_req_i),
    .prof_ack_o  (prof_ack_o),
    .pll_reset_o (pll_reset_o),
    .pll_idsel_o (pll_idsel_o),
    .pll_fbdsel_o(pll_fbdsel_o),
    .pll_odsel_o (pll_odsel_o),
    .sys_rst_n_o (sys_rst_n_o),
    .locked_o    (locked_o),
    .busy_o      (busy_o),
    .fault_o     (fault_o),
    .retry_cnt_o (retry_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] exp_codes(input int p);
    logic [17:0] c;
    case (p)
      0:       c = {6'h3A, 6'h11, 6'h08};
      1:       c = {6'h25, 6'h0F, 6'h04};
      2:       c = {6'h1C, 6'h2E, 6'h02};
      default: c = {6'h07, 6'h33, 6'h3F};
    endcase
    return c;
  endfunction

  task automatic chk_codes(input string tag, input int p);
    chk(tag, {14'd0, pll_idsel_o, pll_fbdsel_o, pll_odsel_o}, {14'd0, exp_codes(p)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until sys_rst_n_o rises; reports cycles taken and ack pulses seen.
  task automatic run_to_run(input int bound, output int cyc, output int acks,
                            output logic ack_at_rise);
    cyc = 0;
    acks = 0;
    while (!sys_rst_n_o && cyc < bound) begin
      tick();
      cyc++;
      if (prof_ack_o) acks++;
    end
    ack_at_rise = prof_ack_o;
  endtask

  int   n;
  int   acks;
  logic ackr;
  int   npulse;
  int   curlen;
  logic prev;
  int   len[4];
  int   rtr[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    pll_lock_i = 1'b0;
    prof_sel_i = 2'd0;
    prof_req_i = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    // Reset state
    chk("rst_pll_reset", pll_reset_o, 1);
    chk_codes("rst_codes", 0);
    chk("rst_sys_rst_n", sys_rst_n_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_busy", busy_o, 1);
    chk("rst_fault", fault_o, 0);
    chk("rst_ack", prof_ack_o, 0);
    chk("rst_retry", retry_cnt_o, 0);

    // Power-up
    #9 rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (pll_reset_o && n < 50);
    chk("pwrup_hold_len", n, 4);
    repeat (10) tick();
    pll_lock_i = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!sys_rst_n_o && n < 50);
    chk("pwrup_lat", n, 10);
    chk("pwrup_locked", locked_o, 1);
    chk("pwrup_busy", busy_o, 0);
    chk("pwrup_retry", retry_cnt_o, 0);
    chk("pwrup_ack", prof_ack_o, 0);

    // Lock loss in RUN
    pll_lock_i = 1'b0;
    n = 0;
    do begin tick(); n++; end while (sys_rst_n_o && n < 20);
    chk("loss_lat", n, 3);
    chk("loss_locked", locked_o, 0);
    chk("loss_pll_reset", pll_reset_o, 1);
    acks = 0;
    n = 0;
    while (pll_reset_o && n < 20) begin
      tick(); n++;
      if (prof_ack_o) acks++;
    end
    chk("loss_hold_len", n, 4);

    // Glitchy lock during STABLE, plus an ignored request in STABLE
    pll_lock_i = 1'b1;
    n = 0;
    while (!sys_rst_n_o && n < 60) begin
      tick(); n++;
      if (prof_ack_o) acks++;
      case (n)
        5:  pll_lock_i = 1'b0;
        7:  pll_lock_i = 1'b1;
        9:  begin
              chk("glitch_busy", busy_o, 1);
              chk("glitch_retry", retry_cnt_o, 0);
            end
        12: begin prof_req_i = 1'b1; prof_sel_i = 2'd3; end
        13: begin
              prof_req_i = 1'b0;
              chk_codes("stable_req_codes", 0);
            end
        default: ;
      endcase
    end
    chk("glitch_lat", n, 17);
    chk("glitch_retry_end", retry_cnt_o, 0);
    chk_codes("glitch_codes", 0);
    chk("loss_no_ack", acks, 0);

    // Profile switch to 2
    prof_req_i = 1'b1;
    prof_sel_i = 2'd2;
    tick();
    prof_req_i = 1'b0;
    chk("sw_sys_rst_n", sys_rst_n_o, 0);
    chk("sw_pll_reset", pll_reset_o, 1);
    chk_codes("sw_codes_hold", 2);
    chk("sw_busy", busy_o, 1);
    run_to_run(60, n, acks, ackr);
    chk("sw_lat", n, 12);
    chk("sw_ack_at_rise", ackr, 1);
    chk("sw_ack_count", acks, 1);
    tick();
    chk("sw_ack_single", prof_ack_o, 0);
    chk_codes("sw_codes_run", 2);

    // Timeout / fault
    pll_lock_i = 1'b0;
    npulse = 0;
    curlen = 0;
    prev = pll_reset_o;
    n = 0;
    while (!fault_o && n < 400) begin
      tick(); n++;
      if (pll_reset_o && !prev && !fault_o && npulse < 4) rtr[npulse] = retry_cnt_o;
      if (pll_reset_o && !fault_o) curlen++;
      if (!pll_reset_o && prev) begin
        if (npulse < 4) len[npulse] = curlen;
        npulse++;
        curlen = 0;
      end
      prev = pll_reset_o;
    end
    chk("to_pulses", npulse, 3);
    for (int i = 0; i < 3 && i < npulse; i++) begin
      chk($sformatf("to_len%0d", i), len[i], 4);
      chk($sformatf("to_retry%0d", i), rtr[i], i);
    end
    chk("to_fault", fault_o, 1);
    chk("to_busy", busy_o, 0);
    chk("to_sys_rst_n", sys_rst_n_o, 0);
    repeat (5) tick();
    chk("fault_pll_reset", pll_reset_o, 1);
    chk("fault_hold", fault_o, 1);

    // Exit FAULT with a request for profile 1
    prof_req_i = 1'b1;
    prof_sel_i = 2'd1;
    tick();
    prof_req_i = 1'b0;
    chk("fexit_fault", fault_o, 0);
    chk("fexit_busy", busy_o, 1);
    chk("fexit_retry", retry_cnt_o, 0);
    chk_codes("fexit_codes", 1);
    pll_lock_i = 1'b1;
    run_to_run(60, n, acks, ackr);
    chk("fexit_run", sys_rst_n_o, 1);
    chk("fexit_ack", ackr, 1);
    chk_codes("fexit_codes_run", 1);

    // Async reset in the middle of WAIT_LOCK
    pll_lock_i = 1'b0;
    n = 0;
    while (sys_rst_n_o && n < 20) begin tick(); n++; end
    n = 0;
    while (pll_reset_o && n < 20) begin tick(); n++; end
    tick();
    tick();
    chk_codes("wait_codes_before", 1);
    chk("wait_pll_reset", pll_reset_o, 0);
    rst_n = 1'b0;
    #2;
    chk("arst_pll_reset", pll_reset_o, 1);
    chk_codes("arst_codes", 0);
    chk("arst_busy", busy_o, 1);
    chk("arst_sys_rst_n", sys_rst_n_o, 0);
    chk("arst_retry", retry_cnt_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_reconfig_sequencer.md
Name: pll_reconfig_sequencer

Overview:
Controls the rPLL that derives the core/video clock from the 27 MHz board reference. The block holds the PLL in reset, waits for a qualified lock, and only then releases the downstream system reset. It recovers automatically from lock loss, with bounded retries, and switches between four divider profiles by driving the rPLL dynamic IDSEL/FBDSEL/ODSEL inputs. It runs on the reference clock, never on the PLL output.

Parameters:
RST_CYCLES, 27, cycles pll_reset_o is held high per attempt (>=1 us at 27 MHz)
LOCK_TIMEOUT, 27000, cycles allowed from reset release to first lock
STABLE_CYCLES, 270, consecutive synchronized lock samples required before release
MAX_RETRY, 3, failed lock attempts tolerated before fault
IDSEL_TABLE, 24'h0, four 6-bit pre-encoded IDSEL codes; profile n is bits [6n+5:6n]
FBDSEL_TABLE, 24'h0, four 6-bit pre-encoded FBDSEL codes, same packing
ODSEL_TABLE, 24'h0, four 6-bit pre-encoded ODSEL codes, same packing

Ports:
clk  in  1  27 MHz reference clock (same net as the PLL clkin)
rst_n  in  1  asynchronous active-low reset
pll_lock_i  in  1  rPLL LOCK, asynchronous to clk
prof_sel_i  in  2  requested profile index
prof_req_i  in  1  request strobe; sampled only in RUN or FAULT
prof_ack_o  out  1  one-cycle pulse when the requested profile reaches RUN
pll_reset_o  out  1  rPLL RESET
pll_idsel_o  out  6  rPLL IDSEL
pll_fbdsel_o  out  6  rPLL FBDSEL
pll_odsel_o  out  6  rPLL ODSEL
sys_rst_n_o  out  1  downstream reset, active low, registered
locked_o  out  1  high only in RUN
busy_o  out  1  high in HOLD, WAIT_LOCK and STABLE
fault_o  out  1  high in FAULT
retry_cnt_o  out  2  failed attempts in the current sequence, saturating

Behaviour:
- Reset (rst_n=0), asynchronous:
  - Outputs: pll_reset_o=1, sel outputs=profile 0 codes, sys_rst_n_o=0, locked_o=0, busy_o=1, fault_o=0, prof_ack_o=0, retry_cnt_o=0.
  - Internal: state=HOLD, all counters 0, active profile=0, ack-pending=0.
- Lock input goes through a 2-flop synchronizer (lock_s), adding 2 cycles of latency. All decisions use lock_s.
- Sel outputs are registered from the active profile. The active profile changes only on the edge that enters HOLD, so codes never change while pll_reset_o=0.
- HOLD:
  - pll_reset_o=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
  - pll_reset_o falls on that same edge. Lock timer is cleared.
- WAIT_LOCK:
  - lock_s=1 goes to STABLE, with the stable counter set to 1.
  - If the timer reaches LOCK_TIMEOUT-1 with no lock: when retry<MAX_RETRY, increment retry and go to HOLD; otherwise go to FAULT.
- STABLE:
  - Each lock_s=1 increments the stable counter. At STABLE_CYCLES go to RUN.
  - lock_s=0 (dropout) clears the stable counter and the lock timer and returns to WAIT_LOCK. A dropout does not increment retry.
- RUN:
  - Entry edge: sys_rst_n_o=1, locked_o=1, busy_o=0, retry cleared. prof_ack_o pulses for 1 cycle if ack-pending, then ack-pending clears.
  - lock_s=0: next edge sets sys_rst_n_o=0 and locked_o=0 and goes to HOLD with the same profile.
  - prof_req_i=1: latch prof_sel_i as the active profile, set ack-pending, sys_rst_n_o=0, go to HOLD.
  - A request to the already-active profile still performs the full resequence.
  - Simultaneous lock loss and request: the request wins and the new profile is applied.
- FAULT:
  - pll_reset_o=1, fault_o=1, sys_rst_n_o=0, busy_o=0.
  - Exit only via rst_n or prof_req_i. A request latches the profile, clears retry, sets ack-pending and goes to HOLD.
- prof_req_i in HOLD, WAIT_LOCK or STABLE is ignored. It is not queued; the requester waits for busy_o=0.
- sys_rst_n_o is never high unless state=RUN. It has no glitch path: it is a registered output only.
- Counters are sized by $clog2 of their parameter. The timer saturates and does not wrap.

Test Plan:
All scenarios use params RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
- Power-up: release rst_n, raise pll_lock_i 10 cycles after pll_reset_o falls -> pll_reset_o high exactly 4 cycles; sys_rst_n_o rises 10 cycles after lock rises (2 sync + 8 stable); retry_cnt_o=0.
- Glitchy lock: pulse pll_lock_i low for 2 cycles at stable count 5 -> returns to WAIT_LOCK, retry unchanged, sys_rst_n_o stays 0 until 8 further consecutive lock samples.
- Timeout/fault: hold pll_lock_i=0 -> 3 HOLD pulses of 4 cycles, retry_cnt_o goes 1 then 2, then fault_o=1 with pll_reset_o held 1; then prof_req_i with prof_sel_i=1 -> fault_o=0 and profile-1 codes on sel outputs.
- Profile switch: in RUN, request prof_sel_i=2 -> sys_rst_n_o falls next edge; sel outputs equal IDSEL_TABLE[17:12] etc. while pll_reset_o=1; prof_ack_o single pulse coincident with sys_rst_n_o rising.
- Lock loss in RUN: drop pll_lock_i -> sys_rst_n_o and locked_o low 3 cycles later (2 sync + 1), full resequence, no prof_ack_o pulse.
- Corner cases: request during STABLE is ignored (codes unchanged, no ack); asserting rst_n mid-WAIT_LOCK gives immediate reset values and profile 0.
